// File: rtl/chnl_pkg.sv
// rtl/chnl_pkg.sv - shared types and constants for the RIFFA channel receive controller
package chnl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RECV,
        DRAIN,
        DONE
    } chnl_rx_state_t;

endpackage

// File: rtl/chnl_rx_ctrl.sv
// rtl/chnl_rx_ctrl.sv - RIFFA RX channel controller: ack handshake, beat pass-through, excess drain
module chnl_rx_ctrl
    import chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int WPB              = C_PCI_DATA_WIDTH / WORD_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        o_val,
    input  logic                        o_rdy,
    output logic [C_PCI_DATA_WIDTH-1:0] o_data,
    output logic                        o_last,
    output logic [$clog2(WPB):0]        o_words,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        abort_o,
    output logic                        ovf_o,
    output logic [31:0]                 cnt_o
);

    localparam int          CW    = $clog2(WPB) + 1;
    localparam logic [31:0] WPB_W = 32'(WPB);

    chnl_rx_state_t state, state_nxt;
    logic [31:0]    rem, rem_nxt, cnt_nxt, beat_words;
    logic           ovf_nxt, abort_nxt;
    logic           armed, armed_nxt;

    // The host's LAST flag and offset carry nothing this controller needs.
    logic unused_inputs;
    assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF};

    assign CHNL_RX_CLK = clk_i;
    assign CHNL_RX_ACK = (state == ACK);
    assign done_o      = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign beat_words  = (rem < WPB_W) ? rem : WPB_W;

    always_comb begin
        state_nxt        = state;
        rem_nxt          = rem;
        cnt_nxt          = cnt_o;
        ovf_nxt          = ovf_o;
        abort_nxt        = 1'b0;
        armed_nxt        = armed | ~CHNL_RX;
        o_val            = 1'b0;
        o_data           = '0;
        o_last           = 1'b0;
        o_words          = '0;
        CHNL_RX_DATA_REN = 1'b0;
        case (state)
            IDLE: begin
                // armed stops a request still held high from being acked twice
                if (CHNL_RX && en_i && armed) begin
                    state_nxt = ACK;
                    rem_nxt   = CHNL_RX_LEN;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    armed_nxt = 1'b0;
                end
            end
            ACK: begin
                state_nxt = (rem != '0) ? RECV : DONE;
            end
            RECV: begin
                o_val            = CHNL_RX_DATA_VALID;
                o_data           = CHNL_RX_DATA;
                CHNL_RX_DATA_REN = o_rdy;
                o_last           = (rem <= WPB_W);
                o_words          = beat_words[CW-1:0];
                if (CHNL_RX_DATA_VALID && o_rdy) begin
                    rem_nxt = rem - beat_words;
                    cnt_nxt = cnt_o + beat_words;
                end
                // A final beat landing with the CHNL_RX fall counts as completion.
                if (rem_nxt == '0) begin
                    state_nxt = CHNL_RX ? DRAIN : DONE;
                end else if (!CHNL_RX) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end
            end
            DRAIN: begin
                CHNL_RX_DATA_REN = 1'b1;
                if (CHNL_RX_DATA_VALID) ovf_nxt = 1'b1;
                if (!CHNL_RX) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            rem     <= '0;
            cnt_o   <= '0;
            ovf_o   <= 1'b0;
            abort_o <= 1'b0;
            armed   <= 1'b1;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            cnt_o   <= cnt_nxt;
            ovf_o   <= ovf_nxt;
            abort_o <= abort_nxt;
            armed   <= armed_nxt;
        end
    end

endmodule

// File: doc/chnl_rx_ctrl.md
CHNL_RX_CTRL -- requirements
Module: chnl_rx_ctrl

Interface
REQ-001 SHALL have parameter C_PCI_DATA_WIDTH, default 32, RIFFA data width in bits: 32, 64 or 128 only.
REQ-002 SHALL have parameter WPB, default C_PCI_DATA_WIDTH/32, the number of 32-bit words per beat; it is derived and never overridden.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All logic runs on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en_i, input, 1 bit: when high, a new transfer may be accepted.
REQ-006 SHALL have RIFFA ports, with directions as seen from this block:
- CHNL_RX_CLK, output, 1 bit; CHNL_RX, input, 1 bit; CHNL_RX_ACK, output, 1 bit.
- CHNL_RX_LAST, input, 1 bit; CHNL_RX_LEN, input, 32 bits, in words; CHNL_RX_OFF, input, 31 bits, unused.
- CHNL_RX_DATA, input, C_PCI_DATA_WIDTH bits; CHNL_RX_DATA_VALID, input, 1 bit; CHNL_RX_DATA_REN, output, 1 bit.
REQ-007 SHALL have downstream ports:
- o_val, output, 1 bit; o_rdy, input, 1 bit; o_data, output, C_PCI_DATA_WIDTH bits.
- o_last, output, 1 bit: this beat holds the final word.
- o_words, output, $clog2(WPB)+1 bits: number of valid words in the beat, LSB-aligned.
REQ-008 SHALL have status ports:
- busy_o, output, 1 bit.
- done_o, output, 1 bit: one-cycle pulse at normal completion.
- abort_o, output, 1 bit: one-cycle pulse when the host drops CHNL_RX early.
- ovf_o, output, 1 bit: sticky; set when excess data is drained.
- cnt_o, output, 32 bits: words delivered in the current or most recent transfer.

Function
REQ-009 SHALL drive CHNL_RX_CLK = clk_i.
REQ-010 SHALL implement the FSM states IDLE, ACK, RECV, DRAIN and DONE.
REQ-011 SHALL move IDLE->ACK when CHNL_RX and en_i are both high, latching rem=CHNL_RX_LEN and clearing cnt_o. While en_i is low, the request is held off: no ACK is issued.
REQ-012 SHALL assert CHNL_RX_ACK for exactly one cycle, in ACK. The next state is RECV if rem>0, otherwise DONE.
REQ-013 SHALL, in RECV, pass data through combinationally:
- o_val = CHNL_RX_DATA_VALID; CHNL_RX_DATA_REN = o_rdy; o_data = CHNL_RX_DATA.
- A beat is accepted only when VALID and REN are both high.
REQ-014 SHALL drive o_last = (rem<=WPB) and o_words = min(rem,WPB) in RECV. Both are 0 in every other state.
REQ-015 SHALL, on each accepted beat, update rem -= o_words and cnt_o += o_words. When rem reaches 0, the next state is DONE if CHNL_RX is low, otherwise DRAIN.
REQ-016 SHALL, in DRAIN, hold o_val=0 and CHNL_RX_DATA_REN=1, discarding beats. Any beat discarded sets ovf_o. The FSM moves to DONE when CHNL_RX goes low.
REQ-017 SHALL, in DONE, pulse done_o for one cycle and then return to IDLE. It re-arms only after CHNL_RX has been seen low, so one request is never double-acked.
REQ-018 SHALL, if CHNL_RX falls in RECV while rem>0, pulse abort_o, return to IDLE and keep cnt_o.
REQ-019 SHALL resolve simultaneous events as follows: if the CHNL_RX fall and the final accepted beat occur in the same cycle, the result is a completion, not an abort.
REQ-020 SHALL hold busy_o=1 in every state except IDLE.
REQ-021 SHALL hold CHNL_RX_DATA_REN=0 in IDLE, ACK and DONE.
REQ-022 SHALL clear ovf_o only on the IDLE->ACK transition.

Reset
REQ-023 SHALL, while rst_ni is low, asynchronously force state=IDLE and rem=0. The outputs cnt_o, ovf_o, done_o, abort_o, busy_o and CHNL_RX_ACK are all 0; all combinational outputs then evaluate to 0.
REQ-024 SHALL treat reset mid-transfer as a hard abort with no abort_o pulse. After release, an asserted CHNL_RX starts a fresh transfer.

Structure
REQ-025 SHALL take the FSM state enum and WORD_W=32 from the shared package chnl_pkg.
REQ-026 SHALL be flat, with no sub-module. Width conversion stays with the existing repacker placed downstream of o_data.

Verification
REQ-027 SHALL cover these directed scenarios:
- Normal transfer, W=64: LEN=5 with o_rdy always 1 -> ACK pulse, then 3 beats with o_words 2,2,1, o_last on beat 3, cnt_o=5, done_o pulse.
- Backpressure, W=32: LEN=4 with o_rdy toggling every cycle -> REN mirrors o_rdy, no beat lost or duplicated, cnt_o=4.
- Zero length: LEN=0 -> ACK, then DONE, with REN never asserted and done_o pulsed.
- Early abort: CHNL_RX drops after 2 of 8 words -> abort_o pulse, cnt_o=2, IDLE, no done_o.
- Overflow: LEN=2 while the host sends 4 words, W=32 -> 2 words forwarded, 2 discarded, ovf_o=1, done_o after CHNL_RX falls.
- Reset mid-RECV, plus en_i=0 held off: all outputs go to 0 immediately; with en_i=0 no ACK is issued until en_i rises.
